// File: rtl/graycode_pkg.sv
// rtl/graycode_pkg.sv - shared width default and binary/Gray conversion helpers
package graycode_pkg;

    localparam int DEFAULT_N = 3;

    // Helpers work on a 32-bit container; callers zero-extend narrower codes.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bintogray_counter_if.sv
// rtl/bintogray_counter_if.sv - control inputs and count outputs of the Gray counter
interface bintogray_counter_if #(
    parameter int N = 3
);
    logic         en;
    logic         up_dn;
    logic         load;
    logic [N-1:0] load_bin;
    logic [N-1:0] binary;
    logic [N-1:0] gray;
    logic         wrap;

    modport master (
        output en, up_dn, load, load_bin,
        input  binary, gray, wrap
    );

    modport slave (
        input  en, up_dn, load, load_bin,
        output binary, gray, wrap
    );
endinterface

// File: rtl/bintogray.sv
// rtl/bintogray.sv - combinational N-bit binary to Gray encoder
module bintogray #(
    parameter int N = 3
) (
    input  logic [N-1:0] bin_i,
    output logic [N-1:0] gray_o
);
    // MSB passes through; every lower bit is the XOR with its upper neighbour.
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/bintogray_counter.sv
// rtl/bintogray_counter.sv - up/down binary counter with registered Gray output and wrap pulse
module bintogray_counter
    import graycode_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst,
    bintogray_counter_if.slave   bus
);

    localparam logic [N-1:0] STEP = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] binary_q, binary_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;

    // Wrap is judged on the old value so no carry-out bit is needed.
    always_comb begin
        binary_d = binary_q;
        wrap_d   = 1'b0;
        if (bus.load) begin
            binary_d = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                binary_d = binary_q + STEP;
                wrap_d   = &binary_q;
            end else begin
                binary_d = binary_q - STEP;
                wrap_d   = ~|binary_q;
            end
        end
    end

    // Encoding the next value keeps gray aligned with binary on the same edge.
    bintogray #(.N(N)) u_enc (
        .bin_i  (binary_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            binary_q <= '0;
            gray_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.binary = binary_q;
    assign bus.gray   = gray_q;
    assign bus.wrap   = wrap_q;

endmodule
